// File: rtl/sdr_16_pkg.sv
// rtl/sdr_16_pkg.sv - SDR command encodings, violation codes and burst ordering
package sdr_16_pkg;

    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_PCH = 3'b010;
    localparam logic [2:0] CMD_RFR = 3'b001;
    localparam logic [2:0] CMD_LMR = 3'b000;

    localparam logic [3:0] ERR_NONE     = 4'd0;
    localparam logic [3:0] ERR_ACT_OPEN = 4'd1;
    localparam logic [3:0] ERR_CLOSED   = 4'd2;
    localparam logic [3:0] ERR_TRCD     = 4'd3;
    localparam logic [3:0] ERR_TRP      = 4'd4;
    localparam logic [3:0] ERR_RFR_OPEN = 4'd5;
    localparam logic [3:0] ERR_TRFC     = 4'd6;
    localparam logic [3:0] ERR_NO_INIT  = 4'd7;
    localparam logic [3:0] ERR_DQ_CLASH = 4'd8;
    localparam logic [3:0] ERR_MODE     = 4'd9;
    localparam logic [3:0] ERR_NO_DATA  = 4'd10;

    // Low column bits of beat k; the burst wraps inside its BL-aligned block.
    function automatic logic [2:0] burst_low(input logic [2:0] low, input logic [2:0] k,
                                             input logic [1:0] bl_lg, input logic bt);
        logic [3:0] m4;
        logic [2:0] nxt;
        m4  = (4'd1 << bl_lg) - 4'd1;
        nxt = bt ? (low ^ k) : (low + k);
        return (low & ~m4[2:0]) | (nxt & m4[2:0]);
    endfunction

endpackage

// File: rtl/sdr_16_mem.sv
// rtl/sdr_16_mem.sv - single-port 16-bit backing store with registered read
module sdr_16_mem #(
    parameter int aw = 13
) (
    input  logic          sdram_clk,
    input  logic          sdram_rst,
    input  logic          we,
    input  logic [aw-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] ram [0:(1<<aw)-1];

    always_ff @(posedge sdram_clk) begin
        if (we) ram[addr] <= wdata;
    end

    // Only the output register is reset; stored contents survive a reset.
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst)  rdata <= '0;
        else if (!we)   rdata <= ram[addr];
    end

endmodule

// File: rtl/sdr_16_responder.sv
// rtl/sdr_16_responder.sv - SDR SDRAM device model: decode, bursts, timing checks
module sdr_16_responder
    import sdr_16_pkg::*;
#(
    parameter int ba_size      = 2,
    parameter int row_size     = 13,
    parameter int col_size     = 9,
    parameter int mem_row_bits = 2,
    parameter int tRCD         = 2,
    parameter int tRP          = 2,
    parameter int tRFC         = 6
) (
    input  logic                sdram_clk,
    input  logic                sdram_rst,
    input  logic [ba_size-1:0]  ba,
    input  logic [row_size-1:0] a,
    input  logic [2:0]          cmd,
    input  logic [15:0]         dq_i,
    input  logic                dq_oe_i,
    output logic [15:0]         dq_o,
    output logic                dq_oe_o,
    output logic                init_done,
    output logic [1:0]          mode_cl,
    output logic [4:0]          mode_bl,
    output logic                err_o,
    output logic [3:0]          err_code,
    output logic [7:0]          err_cnt
);

    localparam int aw = ba_size + mem_row_bits + col_size;

    typedef struct packed {
        logic [ba_size-1:0]      ba;
        logic [mem_row_bits-1:0] row;
        logic [col_size-1:0]     col;
    } burst_t;

    function automatic logic [aw-1:0] beat_addr(input burst_t b, input logic [2:0] k,
                                                input logic [1:0] lg, input logic t);
        return {b.ba, b.row, b.col[col_size-1:3], burst_low(b.col[2:0], k, lg, t)};
    endfunction

    // Only the row bits that reach the backing store are kept per bank.
    logic [3:0]              bank_open;
    logic [mem_row_bits-1:0] bank_row [4];
    logic [7:0]              trcd_cnt [4];
    logic [7:0]              trp_cnt  [4];
    logic [7:0]              rfc_cnt;
    logic [1:0]              bl_lg;
    logic                    bt, wb;
    logic                    wr_act, p0_v, p1_v, rd_act;
    logic [2:0]              wr_k, rd_k;
    burst_t                  wr_b, p0_b, p1_b, rd_b;

    logic is_act, is_rd, is_wr, is_rfr, is_lmr, sel_open, mode_ok;
    logic wr_beat, rd_issue, mem_we;
    logic [2:0] bl_m1;
    logic [aw-1:0] wr_addr, rd_addr;
    logic [10:1] viol;
    logic [3:0] code;
    burst_t new_b;
    logic unused_a_hi;

    assign is_act      = cmd == CMD_ACT;
    assign is_rd       = cmd == CMD_RD;
    assign is_wr       = cmd == CMD_WR;
    assign is_rfr      = cmd == CMD_RFR;
    assign is_lmr      = cmd == CMD_LMR;
    assign sel_open    = bank_open[ba];
    assign new_b       = '{ba: ba, row: bank_row[ba], col: a[col_size-1:0]};
    assign bl_m1       = 3'((4'd1 << bl_lg) - 4'd1);
    assign mode_bl     = 5'd1 << bl_lg;
    assign mode_ok     = (a[6:4] == 3'd2 || a[6:4] == 3'd3) && !a[2];
    assign unused_a_hi = ^a[row_size-1:11];

    always_comb begin
        wr_beat = 1'b0;
        wr_addr = '0;
        if (is_wr) begin
            wr_beat = sel_open;
            wr_addr = beat_addr(new_b, 3'd0, bl_lg, bt);
        end else if (wr_act && !is_rd) begin
            wr_beat = 1'b1;
            wr_addr = beat_addr(wr_b, wr_k, bl_lg, bt);
        end
    end

    // A WR cycle owns the single RAM port and kills any read beats still to come.
    always_comb begin
        rd_issue = 1'b0;
        rd_addr  = '0;
        if (!is_wr && p0_v) begin
            rd_issue = 1'b1;
            rd_addr  = beat_addr(p0_b, 3'd0, bl_lg, bt);
        end else if (!is_wr && rd_act) begin
            rd_issue = 1'b1;
            rd_addr  = beat_addr(rd_b, rd_k, bl_lg, bt);
        end
    end

    assign mem_we = wr_beat && dq_oe_i;

    always_comb begin
        viol               = '0;
        viol[ERR_ACT_OPEN] = is_act && sel_open;
        viol[ERR_CLOSED]   = (is_rd || is_wr) && !sel_open;
        viol[ERR_TRCD]     = (is_rd || is_wr) && trcd_cnt[ba] != 8'd0;
        viol[ERR_TRP]      = is_act && trp_cnt[ba] != 8'd0;
        viol[ERR_RFR_OPEN] = is_rfr && |bank_open;
        viol[ERR_TRFC]     = cmd != CMD_NOP && rfc_cnt != 8'd0;
        viol[ERR_NO_INIT]  = (is_rd || is_wr || is_act) && !init_done;
        viol[ERR_DQ_CLASH] = dq_oe_i && dq_oe_o;
        viol[ERR_MODE]     = is_lmr && !mode_ok;
        viol[ERR_NO_DATA]  = wr_beat && !dq_oe_i;
        code = ERR_NONE;
        for (int i = 10; i >= 1; i--) if (viol[i]) code = 4'(i);
    end

    sdr_16_mem #(.aw(aw)) u_mem (
        .sdram_clk (sdram_clk),
        .sdram_rst (sdram_rst),
        .we        (mem_we),
        .addr      (mem_we ? wr_addr : rd_addr),
        .wdata     (dq_i),
        .rdata     (dq_o)
    );

    always_ff @(posedge sdram_clk) begin
        if (is_act && !sel_open) bank_row[ba] <= a[mem_row_bits-1:0];
    end

    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            bank_open <= '0;
            rfc_cnt   <= '0;
            for (int i = 0; i < 4; i++) begin
                trcd_cnt[i] <= '0;
                trp_cnt[i]  <= '0;
            end
            init_done <= 1'b0;
            mode_cl   <= 2'd2;
            bl_lg     <= 2'd1;
            bt        <= 1'b0;
            wb        <= 1'b0;
            wr_act    <= 1'b0;
            wr_k      <= '0;
            wr_b      <= '0;
            p0_v      <= 1'b0;
            p1_v      <= 1'b0;
            p0_b      <= '0;
            p1_b      <= '0;
            rd_act    <= 1'b0;
            rd_k      <= '0;
            rd_b      <= '0;
            dq_oe_o   <= 1'b0;
            err_o     <= 1'b0;
            err_code  <= ERR_NONE;
            err_cnt   <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (trcd_cnt[i] != 8'd0) trcd_cnt[i] <= trcd_cnt[i] - 8'd1;
                if (trp_cnt[i] != 8'd0)  trp_cnt[i]  <= trp_cnt[i] - 8'd1;
            end
            if (rfc_cnt != 8'd0) rfc_cnt <= rfc_cnt - 8'd1;

            case (cmd)
                CMD_ACT: if (!sel_open) begin
                    bank_open[ba] <= 1'b1;
                    trcd_cnt[ba]  <= 8'(tRCD - 1);
                end
                CMD_PCH: for (int i = 0; i < 4; i++) begin
                    if (a[10] || ba == 2'(i)) begin
                        bank_open[i] <= 1'b0;
                        trp_cnt[i]   <= 8'(tRP - 1);
                    end
                end
                CMD_RFR: rfc_cnt <= 8'(tRFC);
                CMD_LMR: begin
                    init_done <= 1'b1;
                    if (mode_ok) begin
                        wb      <= a[9];
                        mode_cl <= a[5:4];
                        bt      <= a[3];
                        bl_lg   <= a[1:0];
                    end
                end
                default: ;
            endcase

            if (is_wr) begin
                wr_act <= sel_open && !wb && bl_m1 != 3'd0;
                wr_k   <= 3'd1;
                wr_b   <= new_b;
            end else if (is_rd) begin
                wr_act <= 1'b0;
            end else if (wr_act) begin
                wr_k <= wr_k + 3'd1;
                if (wr_k == bl_m1) wr_act <= 1'b0;
            end

            // p1 -> p0 delays a read so its first address goes out at T+CL-1.
            if (is_wr) begin
                p0_v   <= 1'b0;
                p1_v   <= 1'b0;
                rd_act <= 1'b0;
            end else begin
                p1_v <= is_rd && sel_open && mode_cl == 2'd3;
                p1_b <= new_b;
                if (is_rd && sel_open && mode_cl == 2'd2) begin
                    p0_v <= 1'b1;
                    p0_b <= new_b;
                end else begin
                    p0_v <= p1_v;
                    p0_b <= p1_b;
                end
                if (p0_v) begin
                    rd_act <= bl_m1 != 3'd0;
                    rd_k   <= 3'd1;
                    rd_b   <= p0_b;
                end else if (rd_act) begin
                    rd_k <= rd_k + 3'd1;
                    if (rd_k == bl_m1) rd_act <= 1'b0;
                end
            end

            dq_oe_o <= rd_issue;
            err_o   <= code != ERR_NONE;
            if (code != ERR_NONE) begin
                err_code <= code;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sdr_16_responder.sv
// tb/tb_sdr_16_responder.sv - table-driven bench for sdr_16_responder
module tb_sdr_16_responder;
    import sdr_16_pkg::*;

    logic        sdram_clk = 1'b0;
    logic        sdram_rst = 1'b1;
    logic [1:0]  ba = '0;
    logic [12:0] a = '0;
    logic [2:0]  cmd = CMD_NOP;
    logic [15:0] dq_i = '0;
    logic        dq_oe_i = 1'b0;
    logic [15:0] dq_o;
    logic        dq_oe_o, init_done, err_o;
    logic [1:0]  mode_cl;
    logic [4:0]  mode_bl;
    logic [3:0]  err_code;
    logic [7:0]  err_cnt;

    sdr_16_responder dut (
        .sdram_clk (sdram_clk), .sdram_rst (sdram_rst), .ba (ba), .a (a), .cmd (cmd),
        .dq_i (dq_i), .dq_oe_i (dq_oe_i), .dq_o (dq_o), .dq_oe_o (dq_oe_o),
        .init_done (init_done), .mode_cl (mode_cl), .mode_bl (mode_bl),
        .err_o (err_o), .err_code (err_code), .err_cnt (err_cnt)
    );

    always #5 sdram_clk = ~sdram_clk;

    localparam logic [1:0] OFF = 2'd0, ON = 2'd1, ANY = 2'd2;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] a;
        logic [15:0] dq;
        logic        dqoe;
        logic [1:0]  oem;
        logic [15:0] edq;
        logic [3:0]  ecode;
    } vec_t;

    vec_t tbl[$];
    int   total = 0, passed = 0, exp_cnt = 0;
    logic [3:0] last_code = 4'd0;

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s @%0d: got %0h, want %0h", name, idx, got, want);
    endtask

    task automatic v(input logic [2:0] c, input logic [1:0] b, input logic [12:0] ad,
                     input logic [15:0] d = 16'h0, input logic de = 1'b0, input logic [1:0] oem = OFF,
                     input logic [15:0] edq = 16'h0, input logic [3:0] ec = 4'd0);
        tbl.push_back('{c, b, ad, d, de, oem, edq, ec});
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) v(CMD_NOP, 2'd0, 13'h0);
    endtask

    task automatic expect_err(input logic [3:0] ec);
        v(CMD_NOP, 2'd0, 13'h0, 16'h0, 1'b0, OFF, 16'h0, ec);
    endtask

    task automatic beat(input logic [1:0] oem, input logic [15:0] edq);
        v(CMD_NOP, 2'd0, 13'h0, 16'h0, 1'b0, oem, edq);
    endtask

    // One vector per cycle: inputs after the rising edge, outputs checked at the falling edge.
    task automatic run_table();
        foreach (tbl[i]) begin
            cmd = tbl[i].cmd; ba = tbl[i].ba; a = tbl[i].a;
            dq_i = tbl[i].dq; dq_oe_i = tbl[i].dqoe;
            @(negedge sdram_clk);
            if (tbl[i].ecode != 4'd0) begin
                last_code = tbl[i].ecode;
                if (exp_cnt != 255) exp_cnt++;
            end
            check("dq_oe_o", i, 32'(dq_oe_o), 32'(tbl[i].oem != OFF));
            if (tbl[i].oem == ON) check("dq_o", i, 32'(dq_o), 32'(tbl[i].edq));
            check("err_o", i, 32'(err_o), 32'(tbl[i].ecode != 4'd0));
            check("err_code", i, 32'(err_code), 32'(last_code));
            check("err_cnt", i, 32'(err_cnt), 32'(exp_cnt));
            @(posedge sdram_clk);
            #1;
        end
        cmd = CMD_NOP; ba = '0; a = '0; dq_i = '0; dq_oe_i = 1'b0;
        tbl.delete();
    endtask

    initial begin
        repeat (2) @(posedge sdram_clk);
        #1;
        check("rst init_done", -1, 32'(init_done), 32'd0);
        check("rst mode_cl", -1, 32'(mode_cl), 32'd2);
        check("rst mode_bl", -1, 32'(mode_bl), 32'd2);
        check("rst dq_oe_o", -1, 32'(dq_oe_o), 32'd0);
        check("rst err_o", -1, 32'(err_o), 32'd0);
        check("rst err_code", -1, 32'(err_code), 32'd0);
        check("rst err_cnt", -1, 32'(err_cnt), 32'd0);
        sdram_rst = 1'b0;

        // Power-up sequence
        v(CMD_PCH, 2'd0, 13'h400); v(CMD_RFR, 2'd0, 13'h0); nop(6);
        v(CMD_RFR, 2'd0, 13'h0); nop(6); v(CMD_LMR, 2'd0, 13'h021); nop(1);
        run_table();
        check("init init_done", -1, 32'(init_done), 32'd1);
        check("init mode_cl", -1, 32'(mode_cl), 32'd2);
        check("init mode_bl", -1, 32'(mode_bl), 32'd2);

        // CL2 BL2 write then read
        v(CMD_ACT, 2'd1, 13'd5); nop(2);
        v(CMD_WR, 2'd1, 13'd4, 16'hA5A5, 1'b1); v(CMD_NOP, 2'd0, 13'h0, 16'h5A5A, 1'b1);
        v(CMD_RD, 2'd1, 13'd4); nop(1);
        beat(ON, 16'hA5A5); beat(ON, 16'h5A5A); nop(1);
        run_table();

        // CL3 BL4 sequential wrap
        v(CMD_LMR, 2'd0, 13'h032);
        v(CMD_WR, 2'd1, 13'd0, 16'h1111, 1'b1); v(CMD_NOP, 2'd0, 13'h0, 16'h2222, 1'b1);
        v(CMD_NOP, 2'd0, 13'h0, 16'h3333, 1'b1); v(CMD_NOP, 2'd0, 13'h0, 16'h4444, 1'b1);
        v(CMD_RD, 2'd1, 13'd2); nop(2);
        beat(ON, 16'h3333); beat(ON, 16'h4444); beat(ON, 16'h1111); beat(ON, 16'h2222); nop(1);
        run_table();
        check("lmr3 mode_cl", -1, 32'(mode_cl), 32'd3);
        check("lmr3 mode_bl", -1, 32'(mode_bl), 32'd4);

        // Closed-bank read, ACT to open bank keeps the old row
        v(CMD_RD, 2'd2, 13'd0); expect_err(4'd2); nop(4);
        v(CMD_ACT, 2'd1, 13'd6); expect_err(4'd1);
        v(CMD_RD, 2'd1, 13'd4); nop(2);
        beat(ON, 16'hA5A5); beat(ON, 16'h5A5A); beat(ANY, 16'h0); beat(ANY, 16'h0); nop(1);
        run_table();

        // Timing, refresh, bus clash, missing data, bad mode
        v(CMD_ACT, 2'd2, 13'd1); v(CMD_RD, 2'd2, 13'd0); expect_err(4'd3); nop(1);
        for (int i = 0; i < 4; i++) beat(ANY, 16'h0);
        nop(1);
        v(CMD_PCH, 2'd2, 13'h0); v(CMD_ACT, 2'd2, 13'd1); expect_err(4'd4);
        v(CMD_ACT, 2'd0, 13'd0); nop(2);
        v(CMD_RFR, 2'd0, 13'h0); expect_err(4'd5); nop(5);
        v(CMD_LMR, 2'd0, 13'h021); v(CMD_RD, 2'd0, 13'd0); nop(1);
        v(CMD_NOP, 2'd0, 13'h0, 16'h0, 1'b1, ANY);
        v(CMD_NOP, 2'd0, 13'h0, 16'h0, 1'b0, ANY, 16'h0, 4'd8); nop(1);
        v(CMD_WR, 2'd0, 13'd0, 16'h1234, 1'b1); nop(1); expect_err(4'd10);
        v(CMD_LMR, 2'd0, 13'h051); expect_err(4'd9);
        v(CMD_PCH, 2'd0, 13'h400); nop(1); v(CMD_RFR, 2'd0, 13'h0); nop(1);
        v(CMD_ACT, 2'd0, 13'd0); expect_err(4'd6);
        run_table();
        check("badmode mode_cl", -1, 32'(mode_cl), 32'd2);
        check("badmode mode_bl", -1, 32'(mode_bl), 32'd2);

        // Start a CL3 read, then reset in the middle of the burst
        nop(3); v(CMD_LMR, 2'd0, 13'h032); v(CMD_ACT, 2'd1, 13'd5); nop(2);
        v(CMD_RD, 2'd1, 13'd4); nop(2); beat(ON, 16'hA5A5);
        run_table();
        check("pre-rst dq_oe_o", -1, 32'(dq_oe_o), 32'd1);
        check("pre-rst dq_o", -1, 32'(dq_o), 32'h5A5A);
        sdram_rst = 1'b1;
        #1;
        check("async dq_oe_o", -1, 32'(dq_oe_o), 32'd0);
        check("async mode_cl", -1, 32'(mode_cl), 32'd2);
        check("async mode_bl", -1, 32'(mode_bl), 32'd2);
        check("async init_done", -1, 32'(init_done), 32'd0);
        check("async err_cnt", -1, 32'(err_cnt), 32'd0);
        repeat (2) @(posedge sdram_clk);
        #1;
        sdram_rst = 1'b0;
        exp_cnt = 0;
        last_code = 4'd0;

        // ACT before init, then re-init and read back data written before reset
        v(CMD_ACT, 2'd1, 13'd5); expect_err(4'd7);
        v(CMD_LMR, 2'd0, 13'h021); nop(1);
        v(CMD_RD, 2'd1, 13'd4); nop(1);
        beat(ON, 16'hA5A5); beat(ON, 16'h5A5A); nop(1);
        run_table();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sdr_16_responder.md
Name: sdr_16_responder

Overview:
Synthesizable SDR SDRAM responder: the device end of the 16-bit SDR command bus driven by the SDRAM controller FSM.
- Decodes ba/a/cmd and tracks open rows per bank.
- Holds a mode register; stores write data and returns read bursts after the CAS latency.
- Flags protocol and timing violations.
- Sits in the memory-controller testbench and FPGA loopback builds in place of a real SDRAM chip.

Parameters:
- ba_size, 2, bank address width (fixed 2).
- row_size, 13, row address width.
- col_size, 9, column address width.
- mem_row_bits, 2, low row bits kept in backing store; store index = {ba, row[mem_row_bits-1:0], col}.
- tRCD, 2, minimum cycles from ACT to RD/WR on the same bank.
- tRP, 2, minimum cycles from PCH to ACT on the same bank.
- tRFC, 6, cycles after RFR during which only NOP is legal.

Ports:
- sdram_clk  in  1  clock
- sdram_rst  in  1  reset, asynchronous, active-high
- ba  in  2  bank address
- a  in  13  address / mode bits
- cmd  in  3  {ras_n, cas_n, we_n}
- dq_i  in  16  write data from controller
- dq_oe_i  in  1  controller drives dq
- dq_o  out  16  read data
- dq_oe_o  out  1  responder drives dq
- init_done  out  1  LMR has been received
- mode_cl  out  2  current CAS latency
- mode_bl  out  5  current burst length in beats
- err_o  out  1  one-cycle violation pulse
- err_code  out  4  last violation code
- err_cnt  out  8  saturating violation count

Behaviour:
- Command encodings: nop 111, act 011, rd 101, wr 100, pch 010, rfr 001, lmr 000.
- Reset values: dq_o 0, dq_oe_o 0, init_done 0, mode_cl 2, mode_bl 2, bt 0, wb 0, err_o 0, err_code 0, err_cnt 0, all banks closed, all timers expired.
- Reset clears all bursts and pipelines. Backing store contents are not cleared.
- LMR captures a[9] wb, a[6:4] cl, a[3] bt, a[2:0] bl, and sets init_done.
  - cl accepts 2 or 3; bl accepts 000/001/010/011 = 1/2/4/8 beats.
  - Any other cl or bl value: err 9, and the previous mode is kept.
- ACT: opens bank ba with row a[row_size-1:0]. Starts that bank's tRCD timer.
- PCH: a[10]=1 closes all banks; otherwise closes bank ba. Starts tRP for each affected bank. PCH to a closed bank is legal.
- RFR: starts the tRFC window.
- Column address is a[8:0] (a[10] is ignored on RD/WR; no auto-precharge).
- Beat k address: col with its low log2(BL) bits replaced by (col_low + k) mod BL when bt=0, or (col_low XOR k) when bt=1. Wraps within the BL-aligned block.
- Write: WR at cycle T stores dq_i at beats T..T+BL-1, or 1 beat when wb=1.
  - A beat with dq_oe_i=0 is not stored and raises err 10.
  - A new RD/WR truncates the current write burst.
- Read: RD at cycle T drives beat k on dq_o with dq_oe_o=1 at cycle T+CL+k, k=0..BL-1.
  - dq_oe_o is low in every other cycle.
  - A new RD truncates the previous burst: new beats take over from T'+CL.
  - A WR issued during a read burst cancels the remaining read beats.
- Backing store is a synchronous RAM. The read address is issued one cycle before data is due, and dq_o is registered.
- Violation codes:
  - 1: ACT to an open bank.
  - 2: RD/WR to a closed bank.
  - 3: tRCD violated.
  - 4: tRP violated.
  - 5: RFR with any bank open.
  - 6: non-NOP command inside the tRFC window.
  - 7: RD/WR/ACT before init_done.
  - 8: dq_oe_i and dq_oe_o high in the same cycle.
  - 9: unsupported mode.
  - 10: write beat with no data.
- Violation reporting:
  - err_o and err_code are registered and update in the cycle after the offending cycle.
  - When several violations occur in one cycle, the lowest code wins.
  - err_code holds until the next violation.
  - err_cnt increments by 1 per pulse and saturates at 255.
- A violating command still executes, except: an ACT to an open bank is ignored, and an RD/WR to a closed bank returns and stores nothing.

Decomposition:
- Package sdr_16_pkg holds:
  - the cmd encodings;
  - the error code constants;
  - the burst-order function (sequential/interleaved beat address).
- Sub-module sdr_16_mem: single-port synchronous RAM, 16 bits wide, 2^(2+mem_row_bits+col_size) words, with registered read.

Test Plan:
1. Init sequence: PCH a[10]=1, RFR, 6 NOP, RFR, 6 NOP, LMR a=0x021 -> init_done=1, mode_cl=2, mode_bl=2, err_cnt=0.
2. Write then read:
   - ACT ba=1 row=5, 2 NOP, then WR col 4 with dq_i 0xA5A5,0x5A5A and dq_oe_i=1.
   - Then RD col 4 at T -> dq_o 0xA5A5 at T+2, 0x5A5A at T+3; dq_oe_o high exactly those 2 cycles.
3. Wrap-around:
   - LMR a=0x032 (CL3, BL4); write 0x1111..0x4444 at col 0.
   - RD col 2 at T -> 0x3333, 0x4444, 0x1111, 0x2222 at T+3..T+6.
4. Open/closed bank errors:
   - RD to closed ba=2 -> err_o pulse next cycle, err_code=2, dq_oe_o stays 0.
   - ACT ba=1 while open -> err_code=1; the stored row is unchanged.
5. Timing errors:
   - ACT then RD 1 cycle later -> err_code=3.
   - PCH then ACT 1 cycle later -> 4.
   - RFR with bank 0 open -> 5.
   - RD at T plus dq_oe_i=1 at T+2 -> 8.
6. Reset mid-burst:
   - Assert sdram_rst during a read burst -> dq_oe_o=0 immediately, mode back to CL2/BL2.
   - After re-init, re-ACT and RD -> previously written 0xA5A5 is returned.
